// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate pad bus: each grant either drives or samples the bus
// for up to MAX_BEATS beats, and every drive phase is followed by TURN_CYC cycles of Z.
module tristate_bus_arbiter #(
    parameter int WIDTH     = 2,
    parameter int MAX_BEATS = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    inout  wire  [WIDTH-1:0] io,
    output logic [1:0]       gnt,
    output logic             beat,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int TRN_W = $clog2(TURN_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
    localparam logic [TRN_W-1:0] TRN_LAST = TRN_W'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        TURN   = 2'd3
    } state_t;

    state_t             state_q;
    logic               sel_q;
    logic               ptr_q;
    logic               dir_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TRN_W-1:0]   trn_q;
    logic [1:0]         gnt_q;
    logic [WIDTH-1:0]   rdata_q;
    logic               rvalid_q;

    logic               sel_d;
    logic               owner_req;
    logic               release_d;
    logic               drive_en;

    // On a tie the requester that did not own the bus last time wins.
    assign sel_d     = (req == 2'b11) ? ~ptr_q : req[1];
    assign owner_req = req[sel_q];
    assign beat      = ((state_q == DRIVE) || (state_q == SAMPLE)) && owner_req;
    assign release_d = !owner_req || (cnt_q == CNT_LAST);

    // Output enable comes only from registers so the pads never glitch on req changes.
    assign drive_en  = (state_q == DRIVE) && dir_q;
    assign io        = drive_en ? (sel_q ? wdata1 : wdata0) : {WIDTH{1'bz}};

    assign gnt       = gnt_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // rvalid is a one-cycle strobe with no ready: rdata holds the sample taken on the
    // previous beat and stays put until the next sample beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            ptr_q    <= 1'b1;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            trn_q    <= '0;
            gnt_q    <= 2'b00;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel_q   <= sel_d;
                        ptr_q   <= sel_d;
                        dir_q   <= we[sel_d];
                        cnt_q   <= '0;
                        gnt_q   <= sel_d ? 2'b10 : 2'b01;
                        state_q <= we[sel_d] ? DRIVE : SAMPLE;
                    end
                end
                DRIVE, SAMPLE: begin
                    if ((state_q == SAMPLE) && beat) begin
                        rdata_q  <= io;
                        rvalid_q <= 1'b1;
                    end
                    if (release_d) begin
                        gnt_q   <= 2'b00;
                        trn_q   <= '0;
                        state_q <= (state_q == DRIVE) ? TURN : IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TURN: begin
                    if (trn_q == TRN_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        trn_q <= trn_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Vector-table bench for tristate_bus_arbiter; a second instance with TURN_CYC=2 covers the
// longer turnaround. Both buses carry pull-ups, so an undriven bus reads all ones.
module tb_tristate_bus_arbiter;

    localparam logic [1:0] ZZ = 2'b11;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] wd0;
    logic [1:0] wd1;
    logic       io_en;
    logic [1:0] io_drv;

    wire  [1:0] io_a;
    logic [1:0] gnt_a;
    logic       beat_a;
    logic [1:0] rdata_a;
    logic       rvalid_a;
    logic       busy_a;
    logic [1:0] dbg_a;

    wire  [1:0] io_b;
    logic [1:0] gnt_b;
    logic       beat_b;
    logic [1:0] rdata_b;
    logic       rvalid_b;
    logic       busy_b;
    logic [1:0] dbg_b;

    int checks;
    int failures;

    pullup pu_a (io_a);
    pullup pu_b (io_b);
    assign io_a = io_en ? io_drv : 2'bzz;

    tristate_bus_arbiter #(.WIDTH(2), .MAX_BEATS(4), .TURN_CYC(1)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata0(wd0), .wdata1(wd1),
        .io(io_a), .gnt(gnt_a), .beat(beat_a), .rdata(rdata_a), .rvalid(rvalid_a),
        .busy(busy_a), .dbg_state(dbg_a)
    );

    tristate_bus_arbiter #(.WIDTH(2), .MAX_BEATS(4), .TURN_CYC(2)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata0(wd0), .wdata1(wd1),
        .io(io_b), .gnt(gnt_b), .beat(beat_b), .rdata(rdata_b), .rvalid(rvalid_b),
        .busy(busy_b), .dbg_state(dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       chk;
        logic       rst;
        logic [1:0] req;
        logic [1:0] we;
        logic [1:0] wd0;
        logic [1:0] wd1;
        logic       io_en;
        logic [1:0] io_drv;
        logic [1:0] gnt;
        logic       beat;
        logic [1:0] io;
        logic       rvalid;
        logic [1:0] rdata;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic r, input logic [1:0] rq,
                                input logic [1:0] w, input logic [1:0] d0, input logic [1:0] d1,
                                input logic ie, input logic [1:0] id, input logic [1:0] g,
                                input logic b, input logic [1:0] o, input logic rv,
                                input logic [1:0] rd, input logic bz);
        vec_t v;
        v.chk = c;   v.rst = r;   v.req = rq;  v.we = w;     v.wd0 = d0;  v.wd1 = d1;
        v.io_en = ie; v.io_drv = id; v.gnt = g; v.beat = b;  v.io = o;
        v.rvalid = rv; v.rdata = rd; v.busy = bz;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [1:0] act,
                         input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic step_b(input int idx, input logic r, input logic [1:0] rq, input logic [1:0] w,
                          input logic [1:0] g, input logic b, input logic [1:0] o,
                          input logic bz);
        @(negedge clk);
        rst = r;
        req = rq;
        we  = w;
        #1;
        check("b_gnt",  idx, gnt_b, g);
        check("b_beat", idx, {1'b0, beat_b}, {1'b0, b});
        check("b_io",   idx, io_b, o);
        check("b_busy", idx, {1'b0, busy_b}, {1'b0, bz});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 2'b00;
        we       = 2'b00;
        wd0      = 2'b01;
        wd1      = 2'b10;
        io_en    = 1'b0;
        io_drv   = 2'b00;

        //                 c  r  req    we     wd0    wd1    ie  idrv   gnt   bt io  rv rdata  busy
        // reset
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        // requester 0 drives two beats, then drops req; data follows wdata0 in the release cycle
        vecs.push_back(mk(1, 0, 2'b01, 2'b01, 2'b10, 2'b01, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        vecs.push_back(mk(1, 0, 2'b01, 2'b01, 2'b10, 2'b01, 0, 2'b00, 2'b01, 1, 2'b10, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b01, 2'b01, 2'b10, 2'b01, 0, 2'b00, 2'b01, 1, 2'b10, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b01, 2'b01, 2'b01, 0, 2'b00, 2'b01, 0, 2'b01, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        // both drive continuously: 4 beats each, TURN, IDLE, alternate owners
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b01, 1, 2'b01, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b10, 1, 2'b10, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b01, 1, 2'b01, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b11, 2'b01, 2'b10, 0, 2'b00, 2'b01, 0, 2'b01, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        // requester 1 samples one beat of 01; a late we change is ignored; no TURN afterwards
        vecs.push_back(mk(1, 0, 2'b10, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        vecs.push_back(mk(1, 0, 2'b10, 2'b00, 2'b01, 2'b10, 1, 2'b01, 2'b10, 1, 2'b01, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 2'b00, 2'b10, 0, ZZ, 1, 2'b01, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b01, 0));
        // reset in the second drive beat of requester 0; next tie goes back to requester 0
        vecs.push_back(mk(1, 0, 2'b01, 2'b01, 2'b10, 2'b01, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b01, 0));
        vecs.push_back(mk(1, 0, 2'b01, 2'b01, 2'b10, 2'b01, 0, 2'b00, 2'b01, 1, 2'b10, 0, 2'b01, 1));
        vecs.push_back(mk(1, 1, 2'b01, 2'b01, 2'b10, 2'b01, 0, 2'b00, 2'b01, 1, 2'b10, 0, 2'b01, 1));
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 2'b10, 2'b01, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));
        vecs.push_back(mk(1, 0, 2'b00, 2'b11, 2'b10, 2'b01, 0, 2'b00, 2'b01, 0, 2'b10, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 1));
        vecs.push_back(mk(1, 0, 2'b00, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'b00, 0, ZZ, 0, 2'b00, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            req    = vecs[i].req;
            we     = vecs[i].we;
            wd0    = vecs[i].wd0;
            wd1    = vecs[i].wd1;
            io_en  = vecs[i].io_en;
            io_drv = vecs[i].io_drv;
            #1;
            if (vecs[i].chk) begin
                check("gnt",    i, gnt_a, vecs[i].gnt);
                check("beat",   i, {1'b0, beat_a}, {1'b0, vecs[i].beat});
                check("io",     i, io_a, vecs[i].io);
                check("rvalid", i, {1'b0, rvalid_a}, {1'b0, vecs[i].rvalid});
                check("rdata",  i, rdata_a, vecs[i].rdata);
                check("busy",   i, {1'b0, busy_a}, {1'b0, vecs[i].busy});
            end
        end

        // TURN_CYC=2 instance: one drive beat from requester 0, requester 1 waiting
        wd0   = 2'b10;
        wd1   = 2'b01;
        io_en = 1'b0;
        step_b(0,  1'b1, 2'b00, 2'b00, 2'b00, 1'b0, ZZ,    1'b0);
        step_b(1,  1'b0, 2'b01, 2'b01, 2'b00, 1'b0, ZZ,    1'b0);
        step_b(2,  1'b0, 2'b11, 2'b11, 2'b01, 1'b1, 2'b10, 1'b1);
        step_b(3,  1'b0, 2'b10, 2'b11, 2'b01, 1'b0, 2'b10, 1'b1);
        step_b(4,  1'b0, 2'b10, 2'b11, 2'b00, 1'b0, ZZ,    1'b1);
        step_b(5,  1'b0, 2'b10, 2'b11, 2'b00, 1'b0, ZZ,    1'b1);
        step_b(6,  1'b0, 2'b10, 2'b11, 2'b00, 1'b0, ZZ,    1'b0);
        step_b(7,  1'b0, 2'b10, 2'b11, 2'b10, 1'b1, 2'b01, 1'b1);
        step_b(8,  1'b0, 2'b00, 2'b11, 2'b10, 1'b0, 2'b01, 1'b1);
        step_b(9,  1'b0, 2'b00, 2'b00, 2'b00, 1'b0, ZZ,    1'b1);
        step_b(10, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, ZZ,    1'b1);
        step_b(11, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, ZZ,    1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
